// File: rtl/dyser_fifo_param.sv
// Parametrised circular-buffer FIFO for DySER switch/FU links: zero-latency pop,
// optional empty bypass, occupancy/almost-full status and sticky error flags.
module dyser_fifo_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter bit BYPASS       = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             d_in,
  input  logic                         enq,
  input  logic                         deq,
  input  logic                         flush,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             d_out,
  output logic                         valid,
  output logic                         busy,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic active, is_empty, is_full;
  logic bypass_hit, do_pop, do_push, refuse, starve;

  assign active   = !flush && !rst;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Simultaneous enq+deq on a full FIFO frees the head slot, so the push is accepted.
  assign bypass_hit = BYPASS && active && enq && deq && is_empty;
  assign do_pop     = active && deq && !is_empty;
  assign do_push    = active && enq && (!is_full || deq) && !bypass_hit;
  assign refuse     = active && enq && is_full && !deq;
  assign starve     = active && deq && is_empty && !bypass_hit;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = refuse | (overflow_q & ~clr_err);
    underflow_d = starve | (underflow_q & ~clr_err);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= d_in;
  end

  assign d_out       = bypass_hit ? d_in : mem_q[rd_ptr_q];
  assign valid       = do_pop || bypass_hit;
  assign busy        = refuse;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= CW'(AFULL_THRESH));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dyser_fifo_param.sv
// Directed and reference-model checks for dyser_fifo_param, with a BYPASS=0
// companion instance for the empty enq+deq case.
module tb_dyser_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_in = '0;
  logic       enq = 1'b0, deq = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] d_out;
  logic       valid, busy, empty, full, almost_full, overflow, underflow;
  logic [2:0] count;

  logic [7:0] b_d_in = '0;
  logic       b_enq = 1'b0, b_deq = 1'b0;
  logic [7:0] b_d_out;
  logic       b_valid, b_busy, b_empty, b_full, b_afull, b_ovf, b_unf;
  logic [2:0] b_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dyser_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .d_in(d_in), .enq(enq), .deq(deq), .flush(flush),
    .clr_err(clr_err), .d_out(d_out), .valid(valid), .busy(busy), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow));

  dyser_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .d_in(b_d_in), .enq(b_enq), .deq(b_deq), .flush(1'b0),
    .clr_err(1'b0), .d_out(b_d_out), .valid(b_valid), .busy(b_busy), .empty(b_empty),
    .full(b_full), .almost_full(b_afull), .count(b_count), .overflow(b_ovf),
    .underflow(b_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    enq = 0; deq = 0; flush = 0; clr_err = 0;
  endtask

  logic [7:0] q[$];
  logic       exp_v;
  logic [7:0] exp_d;
  logic       r_pop, r_push;

  initial begin
    // reset
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    tick;
    rst = 0;
    #1;
    chk("idle_empty", empty, 1);
    chk("idle_count", count, 0);
    chk("idle_full", full, 0);
    chk("idle_afull", almost_full, 0);
    chk("idle_ovf", overflow, 0);
    chk("idle_unf", underflow, 0);
    chk("idle_valid", valid, 0);
    chk("idle_busy", busy, 0);

    // fill 1..4 then refused push of 5
    for (int i = 1; i <= 4; i++) begin
      d_in = 8'(i); enq = 1;
      #1 chk("fill_busy", busy, 0);
      tick;
      chk("fill_count", count, i);
      chk("fill_afull", almost_full, (i >= 3));
      chk("fill_empty", empty, 0);
    end
    chk("fill_full", full, 1);
    d_in = 8'd5; enq = 1;
    #1 chk("ovf_busy", busy, 1);
    chk("ovf_valid", valid, 0);
    tick;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);

    // drain 1..4 then underflow
    idle; deq = 1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("pop_valid", valid, 1);
      chk("pop_data", d_out, i);
      tick;
      chk("pop_count", count, 4 - i);
    end
    chk("drain_empty", empty, 1);
    #1 chk("unf_valid", valid, 0);
    tick;
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 0);
    idle; clr_err = 1;
    tick;
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // full FIFO enq+deq across the wrap point
    idle;
    for (int i = 1; i <= 4; i++) begin
      d_in = 8'(i); enq = 1; tick;
    end
    d_in = 8'd9; enq = 1; deq = 1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("wrap_valid", valid, 1);
      chk("wrap_data", d_out, (i < 4) ? i + 1 : 9);
      chk("wrap_busy", busy, 0);
      tick;
      chk("wrap_count", count, 4);
    end
    idle; deq = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("wrap_tail", d_out, 9);
      tick;
    end
    idle;
    chk("wrap_drained", count, 0);
    chk("wrap_ovf", overflow, 0);

    // empty enq+deq: bypass on A, push-only on B
    d_in = 8'hAB; enq = 1; deq = 1;
    b_d_in = 8'hAB; b_enq = 1; b_deq = 1;
    #1 chk("byp_valid", valid, 1);
    chk("byp_data", d_out, 8'hAB);
    chk("nobyp_valid", b_valid, 0);
    tick;
    chk("byp_count", count, 0);
    chk("byp_unf", underflow, 0);
    chk("nobyp_count", b_count, 1);
    chk("nobyp_unf", b_unf, 1);
    idle; b_enq = 0; b_deq = 0;

    // flush overrides enq
    for (int i = 0; i < 3; i++) begin
      d_in = 8'(8'h10 + i); enq = 1; tick;
    end
    chk("pre_flush_count", count, 3);
    flush = 1; enq = 1; deq = 1;
    #1 chk("flush_valid", valid, 0);
    chk("flush_busy", busy, 0);
    tick;
    idle;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    chk("flush_unf", underflow, 0);

    // set beats clear on a refused push
    for (int i = 0; i < 4; i++) begin
      d_in = 8'(i); enq = 1; tick;
    end
    enq = 1; clr_err = 1;
    tick;
    chk("setwins_ovf", overflow, 1);
    idle; clr_err = 1;
    tick;
    chk("clr_after_set", overflow, 0);
    idle; flush = 1; tick; idle;

    // random traffic vs. reference queue, async reset mid-run
    q.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc == 250) begin
        enq = 1; deq = 1; d_in = 8'h5A;
        #2 rst = 1;
        #1 chk("arst_count", count, 0);
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_empty", empty, 1);
        tick;
        rst = 0;
        q.delete();
        idle;
        continue;
      end
      enq = 1'($urandom_range(0, 1));
      deq = 1'($urandom_range(0, 1));
      d_in = 8'($urandom);
      chk("rnd_count", count, q.size());
      exp_v = 0; exp_d = '0;
      if (deq && q.size() > 0) begin exp_v = 1; exp_d = q[0]; end
      else if (deq && enq) begin exp_v = 1; exp_d = d_in; end
      r_pop  = deq && q.size() > 0;
      r_push = enq && (q.size() < 4 || deq) && !(enq && deq && q.size() == 0);
      #1 chk("rnd_valid", valid, exp_v);
      if (exp_v) chk("rnd_data", d_out, exp_d);
      chk("rnd_busy", busy, enq && !deq && q.size() == 4);
      if (r_pop) void'(q.pop_front());
      if (r_push) q.push_back(d_in);
      tick;
    end
    idle;
    chk("rnd_final_count", count, q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
